eth_rx_frame_sink: RTL

//  Receive-side AXI-stream consumer for the Ethernet MAC model: accepts rx_axis frames (64-bit beats,

---
 rtl/eth_rx_pkg.sv | 40 ++++
 rtl/eth_keep_popcount.sv | 19 +
 rtl/eth_rx_frame_sink.sv | 129 ++++++++++++
 3 files changed

// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the Ethernet rx_axis frame sink.
package eth_rx_pkg;

  // Default geometry of the rx_axis interface and descriptor.
  localparam int DEF_DATA_W   = 64;
  localparam int DEF_PTP_TS_W = 96;
  localparam int DEF_MAX_LEN  = 9018;
  localparam int DEF_LEN_W    = 16;
  localparam int DEF_CNT_W    = 32;

  // Bit positions inside rx_axis_tuser.
  localparam int TUSER_BAD_BIT = 0;
  localparam int TUSER_TS_LSB  = 1;

  // Frame assembly state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    DROP  = 2'd2
  } rx_state_e;

  // One descriptor per received frame (default widths).
  typedef struct packed {
    logic [DEF_LEN_W-1:0]    len;
    logic [DEF_PTP_TS_W-1:0] ts;
    logic                    err;
    logic                    trunc;
  } rx_desc_t;

  // Byte-enable width for a given data width.
  function automatic int keep_width(input int data_w);
    return data_w / 8;
  endfunction

  // tuser width: timestamp plus the bad-frame bit.
  function automatic int user_width(input int ts_w);
    return ts_w + 1;
  endfunction

endpackage

// File: rtl/eth_keep_popcount.sv
// Counts the number of set byte enables in one rx_axis beat.
module eth_keep_popcount #(
  parameter int KEEP_W = 8,
  parameter int CNT_W  = $clog2(KEEP_W + 1)
) (
  input  logic [KEEP_W-1:0] i_keep,
  output logic [CNT_W-1:0]  o_count
);

  // Sum of the individual enable bits.
  // NOTE: combinational logic uses blocking '=' so the running sum is read back within the same pass; the up-front default also guarantees no latch.
  always_comb begin
    o_count = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      o_count = o_count + CNT_W'(i_keep[i]);
    end
  end

endmodule

// File: rtl/eth_rx_frame_sink.sv
// rx_axis consumer: turns each received frame into a descriptor holding
// byte length, first-beat PTP timestamp and error/truncation flags.
module eth_rx_frame_sink
  import eth_rx_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int PTP_TS_W = DEF_PTP_TS_W,
  parameter  int MAX_LEN  = DEF_MAX_LEN,
  parameter  int LEN_W    = DEF_LEN_W,
  parameter  int CNT_W    = DEF_CNT_W,
  localparam int KEEP_W   = keep_width(DATA_W),
  localparam int USER_W   = user_width(PTP_TS_W)
) (
  input  logic                rx_clk,
  input  logic                rx_rst_n,
  input  logic [DATA_W-1:0]   rx_axis_tdata,
  input  logic [KEEP_W-1:0]   rx_axis_tkeep,
  input  logic                rx_axis_tlast,
  input  logic [USER_W-1:0]   rx_axis_tuser,
  input  logic                rx_axis_tvalid,
  output logic                rx_axis_tready,
  output logic                desc_valid,
  input  logic                desc_ready,
  output logic [LEN_W-1:0]    desc_len,
  output logic [PTP_TS_W-1:0] desc_ts,
  output logic                desc_err,
  output logic                desc_trunc,
  output logic [CNT_W-1:0]    frame_cnt,
  output logic [CNT_W-1:0]    err_cnt
);

  localparam int PC_W = $clog2(KEEP_W + 1);

  rx_state_e           r_state;
  logic [LEN_W-1:0]    r_len;
  logic [PTP_TS_W-1:0] r_ts;
  logic                r_err;

  logic [PC_W-1:0]     w_beat_bytes;
  logic                w_accept;
  logic                w_first;
  logic                w_load;
  logic [LEN_W-1:0]    w_sum;
  logic [LEN_W-1:0]    w_len_next;
  logic                w_trunc_next;
  logic                w_err_next;
  logic                w_err_final;
  logic [PTP_TS_W-1:0] w_ts_next;
  logic                w_unused_data;

  // Payload bytes only matter through tkeep.
  assign w_unused_data = ^rx_axis_tdata;

  eth_keep_popcount #(
    .KEEP_W (KEEP_W),
    .CNT_W  (PC_W)
  ) u_keep_popcount (
    .i_keep  (rx_axis_tkeep),
    .o_count (w_beat_bytes)
  );

  // An open frame is never stalled; a new one waits for a free descriptor slot.
  assign rx_axis_tready = (r_state != IDLE) | ~desc_valid | desc_ready;
  assign w_accept       = rx_axis_tvalid & rx_axis_tready;
  assign w_first        = (r_state == IDLE);
  assign w_load         = w_accept & rx_axis_tlast;

  // Frame totals as they stand once the current beat is folded in.
  always_comb begin
    w_sum        = (w_first ? '0 : r_len) + LEN_W'(w_beat_bytes);
    w_trunc_next = (r_state == DROP) || (w_sum > LEN_W'(MAX_LEN));
    w_len_next   = w_trunc_next ? LEN_W'(MAX_LEN) : w_sum;
    w_err_next   = (w_first ? 1'b0 : r_err) | (~rx_axis_tlast & ~(&rx_axis_tkeep));
    w_err_final  = w_err_next | rx_axis_tuser[TUSER_BAD_BIT] | (w_len_next == '0);
    w_ts_next    = w_first ? rx_axis_tuser[USER_W-1:TUSER_TS_LSB] : r_ts;
  end

  // Frame assembly state machine with running length, timestamp and error.
  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values; all of them are cleared by the async reset.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_ts    <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_len <= w_len_next;
      r_ts  <= w_ts_next;
      r_err <= w_err_next;
      if (rx_axis_tlast) begin
        r_state <= IDLE;
      end else if (w_trunc_next) begin
        r_state <= DROP;
      end else begin
        r_state <= FRAME;
      end
    end
  end

  // Descriptor slot and saturating statistics; a load beats a same-cycle consume.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      desc_valid <= 1'b0;
      desc_len   <= '0;
      desc_ts    <= '0;
      desc_err   <= 1'b0;
      desc_trunc <= 1'b0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
    end else begin
      if (w_load) begin
        desc_valid <= 1'b1;
        desc_len   <= w_len_next;
        desc_ts    <= w_ts_next;
        desc_err   <= w_err_final;
        desc_trunc <= w_trunc_next;
        if (frame_cnt != '1) begin
          frame_cnt <= frame_cnt + CNT_W'(1);
        end
        if ((w_err_final | w_trunc_next) && (err_cnt != '1)) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
      end else if (desc_ready) begin
        desc_valid <= 1'b0;
      end
    end
  end

endmodule
